uart_rx: RTL
============

# uart_rx

Byte-oriented UART receiver with 16x oversampling, the downstream counterpart of the team's `uart_tx`. It recovers 8N1 frames from an asynchronous serial line and presents each byte with a one-cycle valid strobe. It shares `uart_tx`'s `sample_trigger` source, which pulses 16 times per bit, so the two blocks loop back directly.

## Interface
- No parameters. The format is fixed: 8N1, 16 samples per bit, data bits MSB first, matching `uart_tx`.
- `clk`  in  1  system clock; runs much faster than the bit rate.
- `rst`  in  1  synchronous, active-high reset.
- `sample_trigger`  in  1  one-clk pulse at 16x the bit rate; all sampling happens only on these cycles.
- `serial_data`  in  1  asynchronous serial line; idle is 1 (mark).
- `data`  out  8  last correctly received byte; held until the next valid byte.
- `valid`  out  1  one-clk pulse when `data` has been updated.
- `framing_error`  out  1  one-clk pulse when a frame's stop bit is sampled as 0.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer.** `serial_data` passes through a 2-flop synchronizer clocked every clk (not gated by `sample_trigger`). Both flops reset to 1. All logic uses the synchronized value `rx_s`.
- **Sample counter.** `sample_cnt` is 4 bits and counts 0..15 within a bit. It advances only on `sample_trigger` cycles and wraps 15→0 at each bit boundary.
- **Bit counter.** `bit_cnt` is 3 bits and counts data bits 7 down to 0 (MSB first).
- **Bit decision.** The bit value is decided at sample index 8 of each bit; see Configuration.
- **FSM states:**
  - IDLE: on a trigger with `rx_s`=0, go to START with `sample_cnt`=1 (that trigger counts as sample 0).
  - START: at the decision sample, a decided 1 is a false start; return to IDLE with no outputs asserted. Otherwise continue; at sample 15, go to DATA with `bit_cnt`=7.
  - DATA: at the decision sample, shift the decided bit into `shift_reg` (MSB first). At sample 15, decrement `bit_cnt`; after bit 0, go to STOP.
  - STOP: at the decision sample, a decided 1 sets `data`←`shift_reg`, pulses `valid`, and returns to IDLE immediately (mid stop bit), so the next start edge is caught. A decided 0 pulses `framing_error`, leaves `data` unchanged, and goes to WAIT_IDLE.
  - WAIT_IDLE: on a trigger with `rx_s`=1, go to IDLE.
- **`busy`** is 0 only in IDLE.
- **Reset.** `rst` has priority over everything, including a concurrent trigger. Reset mid-frame returns to IDLE with no `valid` or `framing_error` pulse.
- **Reset values:** `data`=8'h00, `valid`=0, `framing_error`=0, `busy`=0, synchronizer=2'b11, FSM=IDLE, counters=0.

## Timing
- **Input latency.** A change on `serial_data` reaches `rx_s` 2 clks later.
- **Output strobes.** `valid` and `framing_error` are registered. Each asserts in the clk after the trigger cycle holding the stop-bit decision sample and stays high exactly 1 clk.
- **Frame latency.** From the first start-bit trigger to `valid` is 16·9+8 = 152 triggers plus 1 clk.
- **Strobe exclusivity.** `valid` and `framing_error` never assert together.
- **Continuous trigger.** A continuously high `sample_trigger` is legal (one sample per clk).
- **Back-to-back frames.** A new start bit is accepted on any trigger in IDLE, including the trigger immediately after the stop-bit decision.

## Configuration
- Macro: `UART_RX_MAJORITY_VOTE_EN`.
- **Defined:** the bit value is the 2-of-3 majority of `rx_s` at samples 7, 8 and 9. The decision, and every action tied to it, takes effect at sample 9.
- **Undefined:** the bit value is the single `rx_s` sample at index 8. All other behaviour is identical.

## Test plan
- **Loopback.** `uart_tx` is driven with 8'hA5 on a shared `sample_trigger` (1 per 4 clks) → exactly one `valid` pulse, `data`=8'hA5, `framing_error` never asserts, `busy` returns to 0.
- **Back-to-back.** 8'h00 then 8'hFF are sent with no idle gap → two `valid` pulses carrying 8'h00 then 8'hFF.
- **False start.** Line is held low for 4 samples, then high → no `valid`, no `framing_error`, `busy` drops to 0 by sample 9.
- **Framing error.** Frame for 8'h3C is sent with stop bit 0, line held low 40 samples, then a correct 8'hC3 frame → one `framing_error` pulse, `data` stays 8'h00 until `valid` with 8'hC3.
- **Reset mid-frame.** `rst` asserted during data bit 4 of 8'h5A → all outputs at reset values, no pulses. The next full 8'h5A frame is received correctly.
- **Glitch rejection.** A 1-sample inverted glitch is placed at sample 8 of data bit 7 of 8'h80 → with `UART_RX_MAJORITY_VOTE_EN`, `data`=8'h80; without it, `data`=8'h00.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling on sample_trigger; data bits arrive MSB first.
// Optional 2-of-3 majority vote at samples 7/8/9 when UART_RX_MAJORITY_VOTE_EN is defined.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | line idle, waiting for a sampled 0 (start edge)
// ST_START     | inside start bit, confirming it at the decision sample
// ST_DATA      | shifting 8 data bits, MSB first
// ST_STOP      | checking the stop bit; leaves at the decision sample
// ST_WAIT_IDLE | after a framing error, waiting for the line to return to 1
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_trigger,
    input  logic       serial_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] DEC_IDX = 4'd9;
`else
    localparam logic [3:0] DEC_IDX = 4'd8;
`endif

    logic [1:0] sync_q;
    logic       rx_s;
    logic       bit_val;
    logic       decision;

    logic [2:0] state_q,      state_d;
    logic [3:0] sample_cnt_q, sample_cnt_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic [7:0] shift_q,      shift_d;
    logic [7:0] data_q,       data_d;
    logic       valid_q,      valid_d;
    logic       fe_q,         fe_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_data};
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    // vote_q[0] holds sample 7, vote_q[1] sample 8; sample 9 is the live rx_s.
    logic [1:0] vote_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vote_q <= 2'b11;
        end else if (sample_trigger) begin
            if (sample_cnt_q == 4'd7) vote_q[0] <= rx_s;
            if (sample_cnt_q == 4'd8) vote_q[1] <= rx_s;
        end
    end

    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign decision = (sample_cnt_q == DEC_IDX);

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        fe_d         = 1'b0;

        if (sample_trigger) begin
            case (state_q)
                ST_IDLE: begin
                    // The trigger that sees the start edge is sample 0.
                    if (!rx_s) begin
                        state_d      = ST_START;
                        sample_cnt_d = 4'd1;
                    end
                end
                ST_START: begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (decision && bit_val) begin
                        state_d      = ST_IDLE;
                        sample_cnt_d = 4'd0;
                    end else if (sample_cnt_q == 4'd15) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd7;
                    end
                end
                ST_DATA: begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (decision) begin
                        shift_d = {shift_q[6:0], bit_val};
                    end
                    if (sample_cnt_q == 4'd15) begin
                        if (bit_cnt_q == 3'd0) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    // Leave mid stop bit so an immediately following start edge is caught.
                    if (decision) begin
                        sample_cnt_d = 4'd0;
                        if (bit_val) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    sample_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= 4'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            fe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            fe_q         <= fe_d;
        end
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign framing_error = fe_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
